// File: rtl/vend_pkg.sv
// Shared types and constants for the vending credit datapath.
package vend_pkg;

  localparam int unsigned CREDIT_W = 7;
  localparam int unsigned SUM_W    = 8;

  localparam logic [CREDIT_W-1:0] NICKEL_C  = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] DIME_C    = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] QUARTER_C = CREDIT_W'(25);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PAYOUT = 2'd1,
    DONE   = 2'd2
  } credit_state_t;

  // One-hot coin choice, ordered {quarter, dime, nickel}.
  typedef struct packed {
    logic q;
    logic d;
    logic n;
  } coin_onehot_t;

endpackage

// File: rtl/coin_select.sv
// coin_select: picks the largest coin not exceeding the given credit.
// Ports:
//   money   - credit to pay from, cents
//   coin_c  - one-hot {q,d,n} choice; all zero when money < 5
//   value_c - value of the chosen coin in cents (0 when none)
module coin_select
  import vend_pkg::*;
(
  input  logic [CREDIT_W-1:0] money,
  output coin_onehot_t        coin_c,
  output logic [CREDIT_W-1:0] value_c
);

  // Greedy choice: quarter, then dime, then nickel.
  always_comb begin
    coin_c  = '0;
    value_c = '0;
    if (money >= QUARTER_C) begin
      coin_c.q = 1'b1;
      value_c  = QUARTER_C;
    end else if (money >= DIME_C) begin
      coin_c.d = 1'b1;
      value_c  = DIME_C;
    end else if (money >= NICKEL_C) begin
      coin_c.n = 1'b1;
      value_c  = NICKEL_C;
    end
  end

endmodule

// File: rtl/coin_credit.sv
// coin_credit: holds running vending credit, accepts/refuses coins,
// deducts spends, and pays remaining credit back one coin per cycle.
// Ports:
//   Clock, Reset (sync, active-low)
//   Nickel/Dime/Quarter - coin deposit pulses
//   SpendValid/SpendAmt - price deduction request
//   Return              - pay back all credit
//   Money               - current credit, cents
//   Reject/Fault        - refused coin / refused spend pulses
//   OutN/OutD/OutQ      - payout coin pulses
//   Busy                - payout in progress
//   ReturnDone          - payout finished pulse
module coin_credit
  import vend_pkg::*;
#(
  parameter int unsigned MAXCREDIT = 95
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Nickel,
  input  logic                Dime,
  input  logic                Quarter,
  input  logic                SpendValid,
  input  logic [CREDIT_W-1:0] SpendAmt,
  input  logic                Return,
  output logic [CREDIT_W-1:0] Money,
  output logic                Reject,
  output logic                Fault,
  output logic                OutN,
  output logic                OutD,
  output logic                OutQ,
  output logic                Busy,
  output logic                ReturnDone
);

  credit_state_t       state, state_nx;
  logic [CREDIT_W-1:0] money_nx;
  logic                reject_nx, fault_nx, busy_nx, rdone_nx;
  coin_onehot_t        out_nx;

  coin_onehot_t        sel_coin;
  logic [CREDIT_W-1:0] sel_val;

  logic [1:0]          coin_cnt;
  logic                any_coin;
  logic [SUM_W-1:0]    coin_val;
  logic                coin_ok;
  logic [SUM_W-1:0]    avail;

  coin_select u_coin_select (
    .money  (Money),
    .coin_c (sel_coin),
    .value_c(sel_val)
  );

  // Coin decode shared by every state.
  always_comb begin
    coin_cnt = 2'(Nickel) + 2'(Dime) + 2'(Quarter);
    any_coin = Nickel | Dime | Quarter;
    coin_val = '0;
    if (Quarter)     coin_val = SUM_W'(QUARTER_C);
    else if (Dime)   coin_val = SUM_W'(DIME_C);
    else if (Nickel) coin_val = SUM_W'(NICKEL_C);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nx  = state;
    money_nx  = Money;
    reject_nx = 1'b0;
    fault_nx  = 1'b0;
    rdone_nx  = 1'b0;
    out_nx    = '0;
    coin_ok   = 1'b0;
    avail     = SUM_W'(Money);

    case (state)
      IDLE: begin
        // Acceptance is judged on pre-spend credit; Return refuses coins.
        coin_ok = (coin_cnt == 2'd1) && !Return &&
                  ((SUM_W'(Money) + coin_val) <= SUM_W'(MAXCREDIT));
        if (coin_ok) avail = SUM_W'(Money) + coin_val;
        reject_nx = any_coin && !coin_ok;
        if (SpendValid) begin
          if (SUM_W'(SpendAmt) <= avail) avail = avail - SUM_W'(SpendAmt);
          else                           fault_nx = 1'b1;
        end
        money_nx = CREDIT_W'(avail);
        if (Return) state_nx = PAYOUT;
      end
      PAYOUT: begin
        reject_nx = any_coin;
        fault_nx  = SpendValid;
        // No selectable coin means credit is exhausted.
        if (sel_coin == '0) begin
          state_nx = DONE;
          rdone_nx = 1'b1;
        end else begin
          out_nx   = sel_coin;
          money_nx = Money - sel_val;
        end
      end
      DONE: begin
        reject_nx = any_coin;
        fault_nx  = SpendValid;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx != IDLE);
  end

  // State and output registers.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state      <= IDLE;
      Money      <= '0;
      Reject     <= 1'b0;
      Fault      <= 1'b0;
      OutN       <= 1'b0;
      OutD       <= 1'b0;
      OutQ       <= 1'b0;
      Busy       <= 1'b0;
      ReturnDone <= 1'b0;
    end else begin
      state      <= state_nx;
      Money      <= money_nx;
      Reject     <= reject_nx;
      Fault      <= fault_nx;
      OutN       <= out_nx.n;
      OutD       <= out_nx.d;
      OutQ       <= out_nx.q;
      Busy       <= busy_nx;
      ReturnDone <= rdone_nx;
    end
  end

endmodule

// File: tb/tb_coin_credit.sv
// Scoreboard bench for coin_credit: a credit/payout model predicts each
// cycle's outputs; a monitor compares them one cycle after each edge.
module tb_coin_credit;
  import vend_pkg::*;

  localparam int MAXC = 95;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       Nickel = 1'b0, Dime = 1'b0, Quarter = 1'b0;
  logic       SpendValid = 1'b0;
  logic [6:0] SpendAmt = '0;
  logic       Return = 1'b0;
  logic [6:0] Money;
  logic       Reject, Fault, OutN, OutD, OutQ, Busy, ReturnDone;

  always #5 Clock = ~Clock;

  coin_credit #(.MAXCREDIT(MAXC)) dut (
    .Clock(Clock), .Reset(Reset), .Nickel(Nickel), .Dime(Dime),
    .Quarter(Quarter), .SpendValid(SpendValid), .SpendAmt(SpendAmt),
    .Return(Return), .Money(Money), .Reject(Reject), .Fault(Fault),
    .OutN(OutN), .OutD(OutD), .OutQ(OutQ), .Busy(Busy),
    .ReturnDone(ReturnDone)
  );

  typedef struct packed {
    logic [6:0] money;
    logic reject, fault, outn, outd, outq, busy, rdone;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model: credit as an integer; a Return expands into the full list of
  // future per-cycle events (coin values, -1 = finished, -2 = back idle).
  int m_credit = 0;
  int m_events[$];

  task automatic model_step(input bit rst, input bit n, input bit d,
                            input bit q, input bit sv, input int sa,
                            input bit ret, output exp_t e);
    e = '0;
    if (!rst) begin
      m_credit = 0;
      m_events.delete();
    end else if (m_events.size() > 0) begin
      int ev = m_events.pop_front();
      e.reject = n | d | q;
      e.fault  = sv;
      e.busy   = (ev != -2);
      if (ev == 25) begin e.outq = 1'b1; m_credit -= 25; end
      if (ev == 10) begin e.outd = 1'b1; m_credit -= 10; end
      if (ev == 5)  begin e.outn = 1'b1; m_credit -= 5;  end
      if (ev == -1) e.rdone = 1'b1;
    end else begin
      int ncoins = int'(n) + int'(d) + int'(q);
      int v = q ? 25 : (d ? 10 : (n ? 5 : 0));
      bit ok = (ncoins == 1) && !ret && (m_credit + v <= MAXC);
      if (ok) m_credit += v;
      e.reject = (ncoins > 0) && !ok;
      if (sv) begin
        if (sa <= m_credit) m_credit -= sa;
        else e.fault = 1'b1;
      end
      if (ret) begin
        int c = m_credit;
        while (c > 0) begin
          int coin = (c >= 25) ? 25 : ((c >= 10) ? 10 : 5);
          m_events.push_back(coin);
          c -= coin;
        end
        m_events.push_back(-1);
        m_events.push_back(-2);
        e.busy = 1'b1;
      end
    end
    e.money = 7'(m_credit);
  endtask

  // Drive one cycle of inputs and queue the predicted response.
  task automatic cyc(input bit rst, input bit n, input bit d, input bit q,
                     input bit sv, input int sa, input bit ret);
    exp_t e;
    @(negedge Clock);
    Reset = rst; Nickel = n; Dime = d; Quarter = q;
    SpendValid = sv; SpendAmt = 7'(sa); Return = ret;
    model_step(rst, n, d, q, sv, sa, ret, e);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  // Direct credit check right after the edge applying the last drive.
  task automatic chk_money(input string name, input int want);
    @(posedge Clock);
    #2;
    checks++;
    if (int'(Money) != want) begin
      errors++;
      $display("FAIL %s Money got %0d want %0d", name, Money, want);
    end
  endtask

  // Monitor: outputs are valid every cycle once a prediction exists.
  initial begin
    exp_t e, got;
    forever begin
      @(posedge Clock);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {Money, Reject, Fault, OutN, OutD, OutQ, Busy, ReturnDone};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got money=%0d rej=%b flt=%b nDQ=%b%b%b busy=%b rdone=%b want money=%0d rej=%b flt=%b nDQ=%b%b%b busy=%b rdone=%b",
                   $time, got.money, got.reject, got.fault, got.outn, got.outd, got.outq, got.busy, got.rdone,
                   e.money, e.reject, e.fault, e.outn, e.outd, e.outq, e.busy, e.rdone);
        end
      end
    end
  end

  initial begin
    // Reset and fill to 85, then MAXCREDIT boundary.
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    idle(1);
    cyc(1, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0);
    chk_money("fill85", 85);
    cyc(1, 0, 0, 1, 0, 0, 0);
    chk_money("over_max", 85);
    cyc(1, 0, 1, 0, 0, 0, 0);
    chk_money("at_max", 95);
    cyc(1, 0, 0, 0, 0, 0, 1);
    idle(8);
    chk_money("payout95", 0);

    // Two coins together, then coin+spend in one cycle.
    cyc(1, 1, 1, 0, 0, 0, 0);
    chk_money("double_coin", 0);
    cyc(1, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 30, 0);
    chk_money("coin_and_spend", 35);

    // Overspend faults.
    cyc(1, 0, 0, 0, 1, 35, 0);
    cyc(1, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 30, 0);
    chk_money("overspend", 20);

    // 40 pays Q, D, N with a dime refused mid-payout.
    cyc(1, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1);
    idle(1);
    cyc(1, 0, 1, 0, 0, 0, 0);
    idle(4);
    chk_money("payout40", 0);

    // Reset during payout of 70.
    cyc(1, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1);
    idle(1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    idle(4);
    chk_money("reset_mid_payout", 0);

    // Zero-credit return.
    cyc(1, 0, 0, 0, 0, 0, 1);
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit rst = ($urandom_range(0, 199) != 0);
      bit n   = ($urandom_range(0, 4) == 0);
      bit d   = ($urandom_range(0, 4) == 0);
      bit q   = ($urandom_range(0, 3) == 0);
      bit sv  = ($urandom_range(0, 5) == 0);
      int sa  = 5 * int'($urandom_range(0, 21));
      bit ret = ($urandom_range(0, 19) == 0);
      cyc(rst, n, d, q, sv, sa, ret);
    end

    @(posedge Clock);
    @(posedge Clock);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
